// File: rtl/mult_share_arbiter.sv
// Round-robin time-sharing of one pipelined signed 8x8 multiplier core among
// NUM_REQ operand requesters; each product comes back tagged with its owner.
module mult_share_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MULT_LAT = 3,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NUM_REQ-1:0]   REQ_VALID,
  input  logic [NUM_REQ*8-1:0] REQ_A,
  input  logic [NUM_REQ*8-1:0] REQ_B,
  output logic [NUM_REQ-1:0]   REQ_READY,
  output logic [7:0]           M_A,
  output logic [7:0]           M_B,
  input  logic [15:0]          M_P,
  output logic                 RES_VALID,
  output logic [ID_W-1:0]      RES_ID,
  output logic [15:0]          RES_P,
  output logic [3:0]           INFLIGHT
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W-1:0] win_id;
  logic            win_found;
  logic [ID_W:0]   scan_idx;
  logic [7:0]      win_a;
  logic [7:0]      win_b;
  logic            accept;
  logic            res_due;

  // Tag stage 0 is loaded on the accept edge; stage MULT_LAT lines up with
  // the core's product so the result register can capture both together.
  logic [MULT_LAT:0] tag_vld;
  logic [ID_W-1:0]   tag_id [0:MULT_LAT];

  // Wrapping priority search starting at the round-robin pointer.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      scan_idx = {1'b0, ptr} + (ID_W+1)'(o);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!win_found && REQ_VALID[scan_idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    REQ_READY = '0;
    win_a     = '0;
    win_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_found && (win_id == ID_W'(i))) begin
        REQ_READY[i] = 1'b1;
        win_a        = REQ_A[8*i +: 8];
        win_b        = REQ_B[8*i +: 8];
      end
    end
  end

  assign accept   = win_found;
  assign res_due  = tag_vld[MULT_LAT];
  assign ptr_next = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + ID_W'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr <= '0;
      M_A <= '0;
      M_B <= '0;
    end else if (accept) begin
      ptr <= ptr_next;
      M_A <= win_a;
      M_B <= win_b;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tag_vld <= '0;
      for (int j = 0; j <= MULT_LAT; j++) begin
        tag_id[j] <= '0;
      end
    end else begin
      tag_vld   <= {tag_vld[MULT_LAT-1:0], accept};
      tag_id[0] <= win_id;
      for (int j = 1; j <= MULT_LAT; j++) begin
        tag_id[j] <= tag_id[j-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RES_VALID <= 1'b0;
      RES_ID    <= '0;
      RES_P     <= '0;
    end else if (res_due) begin
      RES_VALID <= 1'b1;
      RES_ID    <= tag_id[MULT_LAT];
      RES_P     <= M_P;
    end else begin
      RES_VALID <= 1'b0;
    end
  end

  // Pipeline depth bounds the count at MULT_LAT+1, so four bits never wrap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      INFLIGHT <= '0;
    end else begin
      case ({accept, res_due})
        2'b10:   INFLIGHT <= INFLIGHT + 4'd1;
        2'b01:   INFLIGHT <= INFLIGHT - 4'd1;
        default: INFLIGHT <= INFLIGHT;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: a driver predicts grants and products
// from the arbitration rules, a monitor checks every returned result.
module tb_mult_share_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int MULT_LAT = 3;
  localparam int ID_W     = 2;

  logic                 CLK;
  logic                 RST_N;
  logic [NUM_REQ-1:0]   REQ_VALID;
  logic [NUM_REQ*8-1:0] REQ_A;
  logic [NUM_REQ*8-1:0] REQ_B;
  logic [NUM_REQ-1:0]   REQ_READY;
  logic [7:0]           M_A;
  logic [7:0]           M_B;
  logic [15:0]          M_P;
  logic                 RES_VALID;
  logic [ID_W-1:0]      RES_ID;
  logic [15:0]          RES_P;
  logic [3:0]           INFLIGHT;

  typedef struct {
    int          id;
    logic [15:0] p;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   mptr  = 0;

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .MULT_LAT(MULT_LAT), .ID_W(ID_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_READY(REQ_READY),
    .M_A(M_A), .M_B(M_B), .M_P(M_P),
    .RES_VALID(RES_VALID), .RES_ID(RES_ID), .RES_P(RES_P), .INFLIGHT(INFLIGHT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Stand-in for the CLK-only multiplier core: MULT_LAT register stages.
  logic [15:0] p_pipe [0:MULT_LAT-1];
  always @(posedge CLK) begin
    p_pipe[0] <= {{8{M_A[7]}}, M_A} * {{8{M_B[7]}}, M_B};
    for (int j = 1; j < MULT_LAT; j++) p_pipe[j] <= p_pipe[j-1];
  end
  assign M_P = p_pipe[MULT_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lanes(input int x0, input int x1, input int x2, input int x3);
    return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
  endfunction

  function automatic logic [7:0] rnd8();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'h80;
    if (r == 1) return 8'h7F;
    return 8'($urandom);
  endfunction

  // One clock of stimulus: apply inputs, predict the grant, enqueue the result.
  task automatic drive(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                       output int winner);
    exp_t              e;
    logic signed [7:0] sa;
    logic signed [7:0] sb;
    int                pr;
    logic [3:0]        exp_rdy;
    @(negedge CLK);
    REQ_VALID = v;
    REQ_A     = a;
    REQ_B     = b;
    #1;
    winner = -1;
    for (int o = 0; o < NUM_REQ; o++) begin
      int idx;
      idx = (mptr + o) % NUM_REQ;
      if (winner < 0 && v[idx]) winner = idx;
    end
    exp_rdy = (winner >= 0) ? 4'(1 << winner) : 4'b0;
    check("req_ready", 32'(REQ_READY), 32'(exp_rdy));
    if (winner >= 0) begin
      sa    = a[8*winner +: 8];
      sb    = b[8*winner +: 8];
      pr    = int'(sa) * int'(sb);
      e.id  = winner;
      e.p   = pr[15:0];
      e.due = cyc + MULT_LAT + 2;
      sbq.push_back(e);
      mptr  = (winner + 1) % NUM_REQ;
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RST_N) begin
      if (RES_VALID) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL res_unexpected: got RES_VALID=1 id=%0d expected no result", RES_ID);
        end else begin
          e = sbq.pop_front();
          check("res_id", 32'(RES_ID), 32'(e.id));
          check("res_p", 32'(RES_P), 32'(e.p));
          check("res_latency", 32'(cyc), 32'(e.due));
        end
      end
      check("inflight", 32'(INFLIGHT), 32'(sbq.size()));
    end
  end

  initial begin
    int w;
    logic [3:0]  pend;
    logic [31:0] pa;
    logic [31:0] pb;
    logic [3:0]  v;

    RST_N     = 1'b0;
    REQ_VALID = '0;
    REQ_A     = '0;
    REQ_B     = '0;
    #2;
    check("rst_m_a", 32'(M_A), 32'd0);
    check("rst_res_valid", 32'(RES_VALID), 32'd0);
    check("rst_inflight", 32'(INFLIGHT), 32'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    // Single lane: -30 * 40 = -1200
    drive(4'b0001, lanes(-30, 0, 0, 0), lanes(40, 0, 0, 0), w);
    check("single_grant", 32'(w), 32'd0);
    repeat (6) drive(4'b0000, '0, '0, w);

    // Back-to-back lane0, INFLIGHT peaks at 3
    drive(4'b0001, lanes(-30, 0, 0, 0), lanes(40, 0, 0, 0), w);
    drive(4'b0001, lanes(-20, 0, 0, 0), lanes(40, 0, 0, 0), w);
    drive(4'b0001, lanes(-10, 0, 0, 0), lanes(40, 0, 0, 0), w);
    drive(4'b0000, '0, '0, w);
    check("inflight_peak", 32'(INFLIGHT), 32'd3);
    repeat (6) drive(4'b0000, '0, '0, w);
    check("inflight_empty", 32'(INFLIGHT), 32'd0);

    // Extremes
    drive(4'b0001, lanes(-128, 0, 0, 0), lanes(-128, 0, 0, 0), w);
    drive(4'b0001, lanes(127, 0, 0, 0), lanes(-128, 0, 0, 0), w);
    repeat (6) drive(4'b0000, '0, '0, w);

    // Reset with three requests in flight; pointer left at lane 2
    drive(4'b0010, lanes(0, 5, 0, 0), lanes(0, 7, 0, 0), w);
    drive(4'b0010, lanes(0, 6, 0, 0), lanes(0, 7, 0, 0), w);
    drive(4'b0010, lanes(0, 9, 0, 0), lanes(0, 7, 0, 0), w);
    drive(4'b0000, '0, '0, w);
    check("pre_rst_inflight", 32'(INFLIGHT), 32'd3);
    RST_N = 1'b0;
    #1;
    sbq.delete();
    mptr = 0;
    check("mid_rst_m_a", 32'(M_A), 32'd0);
    check("mid_rst_m_b", 32'(M_B), 32'd0);
    check("mid_rst_res_valid", 32'(RES_VALID), 32'd0);
    check("mid_rst_res_id", 32'(RES_ID), 32'd0);
    check("mid_rst_res_p", 32'(RES_P), 32'd0);
    check("mid_rst_inflight", 32'(INFLIGHT), 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      #1;
      check("post_rst_quiet", 32'(RES_VALID), 32'd0);
      check("post_rst_inflight", 32'(INFLIGHT), 32'd0);
    end

    // Round-robin fairness: all lanes held valid for 8 cycles
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, lanes(11, -22, 33, -44), lanes(-5, 6, -7, 8), w);
      check("rr_order", 32'(w), 32'(i % 4));
    end
    repeat (6) drive(4'b0000, '0, '0, w);

    // Sparse/wrap: move pointer to 2, then lanes 1 and 3 compete
    drive(4'b0010, lanes(0, 3, 0, 0), lanes(0, 3, 0, 0), w);
    drive(4'b1010, lanes(0, 13, 0, -17), lanes(0, 19, 0, 23), w);
    check("wrap_first", 32'(w), 32'd3);
    drive(4'b0010, lanes(0, 13, 0, 0), lanes(0, 19, 0, 0), w);
    check("wrap_second", 32'(w), 32'd1);
    repeat (6) drive(4'b0000, '0, '0, w);

    // Randomized traffic; pending lanes hold operands until granted
    pend = '0;
    pa   = '0;
    pb   = '0;
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < NUM_REQ; l++) begin
        if (pend[l] && $urandom_range(0, 99) < 5) begin
          pend[l] = 1'b0;
        end else if (!pend[l] && $urandom_range(0, 99) < 40) begin
          pend[l]       = 1'b1;
          pa[8*l +: 8]  = rnd8();
          pb[8*l +: 8]  = rnd8();
        end
      end
      v = pend;
      drive(v, pa, pb, w);
      if (w >= 0) pend[w] = 1'b0;
    end
    drive(4'b0000, '0, '0, w);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge CLK);
    #1;
    check("drain", 32'(sbq.size()), 32'd0);
    check("final_inflight", 32'(INFLIGHT), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
